// File: rtl/fpu_pkg.sv
// Shared FP32 datapath definitions for the multiply pipeline.
//   Widths and bias constants for the binary32 format and product datapath.
//   fmul_stg2_state_t : control states of the stage-2 mantissa multiplier.
//   mant_of / eff_exp  : operand unpacking helpers (hidden bit, denormal exponent).
package fpu_pkg;

  localparam int unsigned EXP_W    = 8;
  localparam int unsigned FRAC_W   = 23;
  localparam int unsigned MANT_W   = 24;
  localparam int unsigned PROD_W   = 48;
  localparam int unsigned EXP_BIAS = 127;
  localparam int unsigned EXPSUM_W = 10;

  typedef enum logic [1:0] {
    StIdle,
    StMul,
    StDone
  } fmul_stg2_state_t;

  // Significand with the hidden bit restored; denormals (exp == 0) have it clear.
  function automatic logic [MANT_W-1:0] mant_of(logic [EXP_W-1:0] e, logic [FRAC_W-1:0] f);
    return {(e != '0), f};
  endfunction

  // Denormals use the same scale as exponent 1.
  function automatic logic [EXP_W-1:0] eff_exp(logic [EXP_W-1:0] e);
    return (e == '0) ? EXP_W'(1) : e;
  endfunction

endpackage

// File: rtl/fmul_stg2_mant_if.sv
// Stage-2 to stage-3 bundle interface of the FP32 multiplier.
//   Upstream side : in_valid/in_ready handshake plus operand and special-case fields (*_2).
//   Downstream side: out_valid/out_ready handshake plus product, exponent sum and copies (*_3).
//   slave  : view of the stage-2 mantissa block.
//   master : view of the surrounding pipeline (stage 1 driver and stage 3 consumer).
interface fmul_stg2_mant_if;
  import fpu_pkg::*;

  logic                in_valid;
  logic                in_ready;
  logic [EXP_W-1:0]    A_exp_2;
  logic [EXP_W-1:0]    B_exp_2;
  logic [FRAC_W-1:0]   A_frac_2;
  logic [FRAC_W-1:0]   B_frac_2;
  logic                sign_2;
  logic                primal_2;
  logic                error_2;
  logic [EXP_W-1:0]    primal_exp_2;
  logic [FRAC_W-1:0]   primal_frac_2;

  logic                out_valid;
  logic                out_ready;
  logic [PROD_W-1:0]   prod_3;
  logic [EXPSUM_W-1:0] exp_sum_3;
  logic                sign_3;
  logic                primal_3;
  logic                error_3;
  logic [EXP_W-1:0]    primal_exp_3;
  logic [FRAC_W-1:0]   primal_frac_3;

  modport slave (
    input  in_valid, A_exp_2, B_exp_2, A_frac_2, B_frac_2, sign_2, primal_2, error_2,
           primal_exp_2, primal_frac_2, out_ready,
    output in_ready, out_valid, prod_3, exp_sum_3, sign_3, primal_3, error_3,
           primal_exp_3, primal_frac_3
  );

  modport master (
    output in_valid, A_exp_2, B_exp_2, A_frac_2, B_frac_2, sign_2, primal_2, error_2,
           primal_exp_2, primal_frac_2, out_ready,
    input  in_ready, out_valid, prod_3, exp_sum_3, sign_3, primal_3, error_3,
           primal_exp_3, primal_frac_3
  );

endinterface

// File: rtl/fmul_partial_mac.sv
// Combinational shift-add step of the iterative mantissa multiplier.
//   acc   : running 48-bit product accumulator
//   ma    : full 24-bit multiplicand
//   chunk : BITS_PER_CYCLE-bit slice of the multiplier for this iteration
//   idx   : iteration number; the partial product is weighted by 2^(BITS_PER_CYCLE*idx)
//   sum   : acc + (ma * chunk) << (BITS_PER_CYCLE*idx)
module fmul_partial_mac
  import fpu_pkg::*;
#(
  parameter int unsigned BITS_PER_CYCLE = 2,
  parameter int unsigned CNT_W          = 4
) (
  input  logic [PROD_W-1:0]         acc,
  input  logic [MANT_W-1:0]         ma,
  input  logic [BITS_PER_CYCLE-1:0] chunk,
  input  logic [CNT_W-1:0]          idx,
  output logic [PROD_W-1:0]         sum
);

  logic [PROD_W-1:0] partial;
  logic [31:0]       shamt;

  always_comb begin
    partial = PROD_W'(ma) * PROD_W'(chunk);
    shamt   = 32'(BITS_PER_CYCLE) * 32'(idx);
    // Exact: the full 24x24 product fits in 48 bits, so no carry is ever lost.
    sum     = acc + (partial << shamt);
  end

endmodule

// File: rtl/fmul_stg2_mant.sv
// Stage 2 of the FP32 multiply pipeline: mantissa product and exponent sum.
//   clk   : rising-edge clock
//   RESET : synchronous active-high reset; discards any in-flight operation
//   bus   : stage-2 input bundle and stage-3 output bundle (slave view)
// One bundle is in flight at a time. Normal operands take ITER shift-add cycles,
// retiring BITS_PER_CYCLE multiplier bits per cycle; primal/error bundles skip
// the multiplier and present a zero product the cycle after acceptance.
// BITS_PER_CYCLE must divide 24.
module fmul_stg2_mant
  import fpu_pkg::*;
#(
  parameter int unsigned BITS_PER_CYCLE = 2
) (
  input  logic              clk,
  input  logic              RESET,
  fmul_stg2_mant_if.slave   bus
);

  localparam int unsigned ITER  = MANT_W / BITS_PER_CYCLE;
  localparam int unsigned CNT_W = (ITER > 1) ? $clog2(ITER) : 1;

  fmul_stg2_state_t state_q, state_d;

  logic [PROD_W-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [MANT_W-1:0]   ma_q, ma_d;
  logic [MANT_W-1:0]   mb_q, mb_d;
  logic [EXPSUM_W-1:0] exp_sum_q, exp_sum_d;
  logic                sign_q, sign_d;
  logic                primal_q, primal_d;
  logic                error_q, error_d;
  logic [EXP_W-1:0]    pexp_q, pexp_d;
  logic [FRAC_W-1:0]   pfrac_q, pfrac_d;

  logic                in_ready;
  logic [PROD_W-1:0]   mac_sum;

  // The multiplier is shifted right each MUL cycle, so its low bits are always
  // the slice belonging to iteration cnt_q.
  fmul_partial_mac #(
    .BITS_PER_CYCLE (BITS_PER_CYCLE),
    .CNT_W          (CNT_W)
  ) u_mac (
    .acc   (acc_q),
    .ma    (ma_q),
    .chunk (mb_q[BITS_PER_CYCLE-1:0]),
    .idx   (cnt_q),
    .sum   (mac_sum)
  );

  assign in_ready = (state_q == StIdle) && !RESET;

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    ma_d      = ma_q;
    mb_d      = mb_q;
    exp_sum_d = exp_sum_q;
    sign_d    = sign_q;
    primal_d  = primal_q;
    error_d   = error_q;
    pexp_d    = pexp_q;
    pfrac_d   = pfrac_q;

    unique case (state_q)
      StIdle: begin
        if (bus.in_valid && in_ready) begin
          ma_d      = mant_of(bus.A_exp_2, bus.A_frac_2);
          mb_d      = mant_of(bus.B_exp_2, bus.B_frac_2);
          // Range -125..383 fits a 10-bit two's-complement value.
          exp_sum_d = EXPSUM_W'(eff_exp(bus.A_exp_2)) + EXPSUM_W'(eff_exp(bus.B_exp_2))
                      - EXPSUM_W'(EXP_BIAS);
          sign_d    = bus.sign_2;
          primal_d  = bus.primal_2;
          error_d   = bus.error_2;
          pexp_d    = bus.primal_exp_2;
          pfrac_d   = bus.primal_frac_2;
          acc_d     = '0;
          cnt_d     = '0;
          state_d   = (bus.primal_2 || bus.error_2) ? StDone : StMul;
        end
      end

      StMul: begin
        acc_d = mac_sum;
        mb_d  = mb_q >> BITS_PER_CYCLE;
        if (cnt_q == CNT_W'(ITER - 1)) begin
          cnt_d   = '0;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      StDone: begin
        if (bus.out_ready) begin
          state_d = StIdle;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (RESET) begin
      state_q   <= StIdle;
      acc_q     <= '0;
      cnt_q     <= '0;
      ma_q      <= '0;
      mb_q      <= '0;
      exp_sum_q <= '0;
      sign_q    <= 1'b0;
      primal_q  <= 1'b0;
      error_q   <= 1'b0;
      pexp_q    <= '0;
      pfrac_q   <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      ma_q      <= ma_d;
      mb_q      <= mb_d;
      exp_sum_q <= exp_sum_d;
      sign_q    <= sign_d;
      primal_q  <= primal_d;
      error_q   <= error_d;
      pexp_q    <= pexp_d;
      pfrac_q   <= pfrac_d;
    end
  end

  // All outputs come straight from registers; only in_ready also sees RESET.
  assign bus.in_ready      = in_ready;
  assign bus.out_valid     = (state_q == StDone);
  assign bus.prod_3        = acc_q;
  assign bus.exp_sum_3     = exp_sum_q;
  assign bus.sign_3        = sign_q;
  assign bus.primal_3      = primal_q;
  assign bus.error_3       = error_q;
  assign bus.primal_exp_3  = pexp_q;
  assign bus.primal_frac_3 = pfrac_q;

endmodule

// File: tb/tb_fmul_stg2_mant.sv
// Directed scoreboard bench for fmul_stg2_mant with BITS_PER_CYCLE = 2.
module tb_fmul_stg2_mant;

  localparam int ITER = 12;
  localparam int LAT  = ITER + 1;

  typedef struct packed {
    logic [47:0] prod;
    logic [9:0]  exp_sum;
    logic        sign;
    logic        primal;
    logic        error;
    logic [7:0]  pexp;
    logic [22:0] pfrac;
  } res_t;

  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_err = 0;
  res_t sb[$];

  always #5 clk = ~clk;

  fmul_stg2_mant_if bus ();

  fmul_stg2_mant #(
    .BITS_PER_CYCLE (2)
  ) dut (
    .clk   (clk),
    .RESET (rst),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference result computed from the fields the bench is driving.
  function automatic res_t model();
    res_t        r;
    logic [47:0] ma, mb;
    logic [9:0]  ea, eb;
    ma = {24'd0, (bus.A_exp_2 != 8'd0), bus.A_frac_2};
    mb = {24'd0, (bus.B_exp_2 != 8'd0), bus.B_frac_2};
    ea = (bus.A_exp_2 == 8'd0) ? 10'd1 : {2'b00, bus.A_exp_2};
    eb = (bus.B_exp_2 == 8'd0) ? 10'd1 : {2'b00, bus.B_exp_2};
    r.prod    = (bus.primal_2 || bus.error_2) ? 48'd0 : ma * mb;
    r.exp_sum = ea + eb - 10'd127;
    r.sign    = bus.sign_2;
    r.primal  = bus.primal_2;
    r.error   = bus.error_2;
    r.pexp    = bus.primal_exp_2;
    r.pfrac   = bus.primal_frac_2;
    return r;
  endfunction

  task automatic set_in(input logic [7:0] ae, input logic [22:0] af, input logic [7:0] be,
                        input logic [22:0] bf, input logic s, input logic p, input logic e,
                        input logic [7:0] pe, input logic [22:0] pf);
    bus.A_exp_2       = ae;
    bus.A_frac_2      = af;
    bus.B_exp_2       = be;
    bus.B_frac_2      = bf;
    bus.sign_2        = s;
    bus.primal_2      = p;
    bus.error_2       = e;
    bus.primal_exp_2  = pe;
    bus.primal_frac_2 = pf;
    bus.in_valid      = 1'b1;
  endtask

  // Waits (bounded) for in_ready, lets the accepting edge pass, records the
  // expectation and returns on the following negedge with in_valid dropped.
  task automatic accept(input string tag);
    int w = 0;
    while (bus.in_ready !== 1'b1 && w < 50) begin
      @(negedge clk);
      w++;
    end
    check({tag, "_in_ready"}, 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    sb.push_back(model());
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  // Latency counts the acceptance cycle as cycle 0.
  task automatic wait_valid(input string tag, input int exp_lat);
    int lat = 1;
    while (bus.out_valid !== 1'b1 && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_out_valid"}, 64'(bus.out_valid), 64'd1);
    check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
  endtask

  task automatic check_front(input string tag);
    res_t r;
    check({tag, "_sb_nonempty"}, 64'(sb.size() != 0), 64'd1);
    if (sb.size() != 0) begin
      r = sb[0];
      check({tag, "_prod"}, 64'(bus.prod_3), 64'(r.prod));
      check({tag, "_exp_sum"}, 64'(bus.exp_sum_3), 64'(r.exp_sum));
      check({tag, "_sign"}, 64'(bus.sign_3), 64'(r.sign));
      check({tag, "_primal"}, 64'(bus.primal_3), 64'(r.primal));
      check({tag, "_error"}, 64'(bus.error_3), 64'(r.error));
      check({tag, "_pexp"}, 64'(bus.primal_exp_3), 64'(r.pexp));
      check({tag, "_pfrac"}, 64'(bus.primal_frac_3), 64'(r.pfrac));
    end
  endtask

  task automatic release_result(input string tag);
    res_t r;
    bus.out_ready = 1'b1;
    @(posedge clk);
    if (sb.size() != 0) r = sb.pop_front();
    @(negedge clk);
    bus.out_ready = 1'b0;
    check({tag, "_drop_valid"}, 64'(bus.out_valid), 64'd0);
  endtask

  task automatic run_one(input string tag, input int exp_lat);
    accept(tag);
    wait_valid(tag, exp_lat);
    check_front(tag);
    release_result(tag);
  endtask

  initial begin
    rst           = 1'b1;
    bus.out_ready = 1'b0;
    set_in(8'd0, 23'd0, 8'd0, 23'd0, 1'b0, 1'b0, 1'b0, 8'd0, 23'd0);
    bus.in_valid  = 1'b0;
    repeat (2) @(negedge clk);

    // Reset state
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_in_ready", 64'(bus.in_ready), 64'd0);
    check("rst_prod", 64'(bus.prod_3), 64'd0);
    check("rst_exp_sum", 64'(bus.exp_sum_3), 64'd0);
    check("rst_flags", 64'({bus.sign_3, bus.primal_3, bus.error_3}), 64'd0);
    check("rst_primal", 64'({bus.primal_exp_3, bus.primal_frac_3}), 64'd0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 64'(bus.in_ready), 64'd1);
    @(negedge clk);

    // 1.0 x 1.0
    set_in(8'd127, 23'd0, 8'd127, 23'd0, 1'b0, 1'b0, 1'b0, 8'd0, 23'd0);
    run_one("one_x_one", LAT);

    // 1.5 x 1.5, negative
    set_in(8'd127, 23'h400000, 8'd127, 23'h400000, 1'b1, 1'b0, 1'b0, 8'd0, 23'd0);
    run_one("onehalf_sq", LAT);

    // Denormal x smallest normal
    set_in(8'd0, 23'd1, 8'd1, 23'd0, 1'b0, 1'b0, 1'b0, 8'd0, 23'd0);
    run_one("denormal", LAT);

    // Primal bypass
    set_in(8'd127, 23'd0, 8'd200, 23'h123, 1'b0, 1'b1, 1'b0, 8'hFF, 23'h400000);
    run_one("bypass_primal", 1);

    // Error bypass
    set_in(8'd3, 23'h7FFFFF, 8'd254, 23'h7FFFFF, 1'b1, 1'b0, 1'b1, 8'h12, 23'h345);
    run_one("bypass_error", 1);

    // Largest mantissas
    set_in(8'd254, 23'h7FFFFF, 8'd254, 23'h7FFFFF, 1'b0, 1'b0, 1'b0, 8'd0, 23'd0);
    run_one("max_mant", LAT);

    // Pseudo-random operands
    for (int n = 0; n < 3; n++) begin
      set_in(8'($urandom_range(0, 254)), 23'($urandom), 8'($urandom_range(0, 254)),
             23'($urandom), 1'($urandom), 1'b0, 1'b0, 8'($urandom), 23'($urandom));
      run_one("random", LAT);
    end

    // Backpressure with a second bundle waiting
    set_in(8'd128, 23'h200000, 8'd126, 23'h600000, 1'b0, 1'b0, 1'b0, 8'd0, 23'd0);
    accept("bp_first");
    wait_valid("bp_first", LAT);
    set_in(8'd130, 23'h0ABCDE, 8'd100, 23'h654321, 1'b1, 1'b0, 1'b0, 8'd7, 23'd9);
    bus.out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      check("bp_hold_valid", 64'(bus.out_valid), 64'd1);
      check("bp_hold_in_ready", 64'(bus.in_ready), 64'd0);
      check_front("bp_hold");
      @(negedge clk);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    if (sb.size() != 0) void'(sb.pop_front());
    @(negedge clk);
    bus.out_ready = 1'b0;
    check("bp_second_ready", 64'(bus.in_ready), 64'd1);
    run_one("bp_second", LAT);

    // Reset in the middle of the multiply
    set_in(8'd127, 23'd0, 8'd127, 23'd0, 1'b1, 1'b0, 1'b0, 8'h55, 23'h1234);
    accept("rst_mid");
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    check("rst_mid_in_ready_low", 64'(bus.in_ready), 64'd0);
    @(posedge clk);
    @(negedge clk);
    check("rst_mid_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_mid_prod", 64'(bus.prod_3), 64'd0);
    check("rst_mid_exp_sum", 64'(bus.exp_sum_3), 64'd0);
    check("rst_mid_flags", 64'({bus.sign_3, bus.primal_3, bus.error_3}), 64'd0);
    check("rst_mid_primal", 64'({bus.primal_exp_3, bus.primal_frac_3}), 64'd0);
    rst = 1'b0;
    sb.delete();
    #1;
    check("rst_mid_in_ready_back", 64'(bus.in_ready), 64'd1);
    @(negedge clk);
    set_in(8'd127, 23'd0, 8'd127, 23'd0, 1'b0, 1'b0, 1'b0, 8'd0, 23'd0);
    run_one("reissue", LAT);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed no end of run, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
